// File: rtl/gpio_link_scheduler_if.sv
// Bus bundle between the GPIO link scheduler, its message requesters and the
// GPIO header pins. The gpio_parity pin exists only when GPIO_LINK_PARITY_EN
// is defined.
interface gpio_link_scheduler_if #(
  parameter int NUM_REQ = 2
) ();
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic [3:0]         tx_nibble;
  logic               nib_rd;
  logic [3:0]         gpio_data;
  logic               gpio_sclk;
  logic               gpio_done;
  logic               busy;
`ifdef GPIO_LINK_PARITY_EN
  logic               gpio_parity;

  modport master (
    input  req, tx_nibble,
    output grant, nib_rd, gpio_data, gpio_sclk, gpio_done, busy, gpio_parity
  );

  modport slave (
    output req, tx_nibble,
    input  grant, nib_rd, gpio_data, gpio_sclk, gpio_done, busy, gpio_parity
  );
`else
  modport master (
    input  req, tx_nibble,
    output grant, nib_rd, gpio_data, gpio_sclk, gpio_done, busy
  );

  modport slave (
    output req, tx_nibble,
    input  grant, nib_rd, gpio_data, gpio_sclk, gpio_done, busy
  );
`endif
endinterface

// File: rtl/gpio_link_scheduler.sv
// Transmit-side scheduler for the 4-bit GPIO message link. Arbitrates
// round-robin among NUM_REQ requesters, pulls MSG_NIBBLES nibbles from the
// granted one and drives data, shared clock and message-done pins.
// Optional macro GPIO_LINK_PARITY_EN adds the gpio_parity pin (XOR of
// gpio_data, registered together with it).
module gpio_link_scheduler #(
  parameter int NUM_REQ     = 2,
  parameter int MSG_NIBBLES = 32,
  parameter int CLK_DIV     = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  resetn,
  gpio_link_scheduler_if.master bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MSG_NIBBLES + 1);
  localparam int DIV_W = 8;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] GRANT = 3'd1;
  localparam logic [2:0] SETUP = 3'd2;
  localparam logic [2:0] LOW   = 3'd3;
  localparam logic [2:0] HIGH  = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] cand;
  logic             sel_found;
  logic [CNT_W-1:0] cnt;
  logic [DIV_W-1:0] div;
  logic             div_last;
  logic             cnt_last;

  // The divider counts every cycle of a phase; widened by one bit so the
  // comparison against CLK_DIV never truncates.
  assign div_last = (({1'b0, div} + 9'd1) == 9'(CLK_DIV));
  assign cnt_last = ((cnt + CNT_W'(1)) == CNT_W'(MSG_NIBBLES));

  // Pin-level strobes are pure state decodes, so they drop to 0 the moment
  // an asynchronous reset forces the state back to IDLE.
  assign bus.nib_rd    = (state == SETUP);
  assign bus.gpio_sclk = (state == HIGH);
  assign bus.gpio_done = (state == DONE);
  assign bus.busy      = (state != IDLE);

  // Round-robin pick: first set request at or after the pointer, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!sel_found && bus.req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Message sequencer: grant, per-nibble SETUP/LOW/HIGH phases, DONE strobe.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      ptr           <= '0;
      gnt_idx       <= '0;
      cnt           <= '0;
      div           <= '0;
      bus.grant     <= '0;
      bus.gpio_data <= '0;
`ifdef GPIO_LINK_PARITY_EN
      bus.gpio_parity <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            bus.grant <= NUM_REQ'(1) << sel_idx;
            gnt_idx   <= sel_idx;
            state     <= GRANT;
          end
        end
        GRANT: begin
          div   <= '0;
          state <= SETUP;
        end
        SETUP: begin
          bus.gpio_data <= bus.tx_nibble;
`ifdef GPIO_LINK_PARITY_EN
          bus.gpio_parity <= ^bus.tx_nibble;
`endif
          // SETUP is the first low cycle of the nibble period.
          if (div_last) begin
            div   <= '0;
            state <= HIGH;
          end else begin
            div   <= div + DIV_W'(1);
            state <= LOW;
          end
        end
        LOW: begin
          if (div_last) begin
            div   <= '0;
            state <= HIGH;
          end else begin
            div <= div + DIV_W'(1);
          end
        end
        HIGH: begin
          if (div_last) begin
            div   <= '0;
            cnt   <= cnt + CNT_W'(1);
            state <= cnt_last ? DONE : SETUP;
          end else begin
            div <= div + DIV_W'(1);
          end
        end
        DONE: begin
          if (div_last) begin
            div       <= '0;
            cnt       <= '0;
            bus.grant <= '0;
            ptr       <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
            state     <= IDLE;
          end else begin
            div <= div + DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_link_scheduler.sv
// Self-checking bench for gpio_link_scheduler (NUM_REQ=2, MSG_NIBBLES=32,
// CLK_DIV=4). A requester model presents nibbles and pushes each captured
// value into an expected queue; the nibble seen on every sclk rise goes into
// an observed queue; scenario tasks compare the two plus timing records.
module tb_gpio_link_scheduler;

  localparam int MSG_CYCLES = 261;  // 1 + 32*2*4 + 4

  logic CLOCK_50 = 1'b0;
  logic resetn   = 1'b1;

  always #5 CLOCK_50 = ~CLOCK_50;

  gpio_link_scheduler_if #(.NUM_REQ(2)) bus ();

  gpio_link_scheduler #(
    .NUM_REQ    (2),
    .MSG_NIBBLES(32),
    .CLK_DIV    (4)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .resetn  (resetn),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;

  // Monitor / requester-model state (written only by the monitor process)
  int         cyc = 0;
  int         gi = 0;
  int         last_hi = 0;
  int         dlen = 0;
  int         glen = 0;
  int         overlap_err = 0;
  int         onehot_err = 0;
  int         src_cnt[2];
  int         seen_tok = 0;
  logic       prev_sclk = 1'b0;
  logic       prev_done = 1'b0;
  logic [1:0] prev_grant = 2'b00;
  logic [3:0] exp_q[$];
  logic [3:0] obs_q[$];
  logic       obs_par_q[$];
  int         rd_cyc_q[$];
  int         grant_len_q[$];
  int         grant_rise_q[$];
  int         done_len_q[$];
  int         done_gap_q[$];
  logic [1:0] grant_seq_q[$];

  // Written only by the scenario tasks
  int clr_tok  = 0;
  int pat_mode = 0;

  // Requester model and event recorder, sampled on the falling edge
  always @(negedge CLOCK_50) begin
    if (clr_tok != seen_tok) begin
      seen_tok = clr_tok;
      exp_q.delete(); obs_q.delete(); obs_par_q.delete(); rd_cyc_q.delete();
      grant_len_q.delete(); grant_rise_q.delete(); done_len_q.delete();
      done_gap_q.delete(); grant_seq_q.delete();
      src_cnt[0] = 0; src_cnt[1] = 0;
      overlap_err = 0; onehot_err = 0;
    end
    cyc = cyc + 1;
    gi  = (bus.grant === 2'b10) ? 1 : 0;
    case (pat_mode)
      0:       bus.tx_nibble = 4'(src_cnt[gi] % 2);
      1:       bus.tx_nibble = 4'(gi * 8 + (src_cnt[gi] % 8));
      default: bus.tx_nibble = ((src_cnt[gi] % 2) == 0) ? 4'b1011 : 4'b0110;
    endcase
    if (bus.nib_rd === 1'b1) begin
      exp_q.push_back(bus.tx_nibble);
      rd_cyc_q.push_back(cyc);
      src_cnt[gi] = src_cnt[gi] + 1;
    end
    if (bus.gpio_sclk === 1'b1 && prev_sclk === 1'b0) begin
      obs_q.push_back(bus.gpio_data);
`ifdef GPIO_LINK_PARITY_EN
      obs_par_q.push_back(bus.gpio_parity);
`endif
    end
    if (bus.gpio_sclk === 1'b1) last_hi = cyc;
    if (bus.gpio_done === 1'b1) begin
      if (prev_done !== 1'b1) begin
        dlen = 1;
        done_gap_q.push_back(cyc - last_hi);
      end else dlen = dlen + 1;
    end else if (prev_done === 1'b1) done_len_q.push_back(dlen);
    if (bus.grant !== 2'b00 && !$isunknown(bus.grant)) begin
      if (prev_grant === 2'b00) begin
        glen = 1;
        grant_seq_q.push_back(bus.grant);
        grant_rise_q.push_back(cyc);
      end else glen = glen + 1;
    end else if (bus.grant === 2'b00 && prev_grant !== 2'b00 && !$isunknown(prev_grant))
      grant_len_q.push_back(glen);
    if (bus.gpio_sclk === 1'b1 && bus.gpio_done === 1'b1) overlap_err = overlap_err + 1;
    if (bus.grant === 2'b11) onehot_err = onehot_err + 1;
    prev_sclk  = bus.gpio_sclk;
    prev_done  = bus.gpio_done;
    prev_grant = bus.grant;
  end

  // Drive-only helper: hold reset, clear the records, release
  task automatic do_reset(input logic [1:0] req_after);
    @(negedge CLOCK_50); #2;
    resetn  = 1'b0;
    bus.req = req_after;
    repeat (2) @(negedge CLOCK_50);
    clr_tok = clr_tok + 1;
    @(negedge CLOCK_50); #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    int bad;
    bus.req = 2'b00;
    resetn  = 1'b0;
    #1;
    tests++; if (bus.grant !== 2'b00) begin fails++; $display("FAIL rst_grant: got %b, expected 00", bus.grant); end
    tests++; if (bus.nib_rd !== 1'b0) begin fails++; $display("FAIL rst_nib_rd: got %b, expected 0", bus.nib_rd); end
    tests++; if (bus.gpio_data !== 4'h0) begin fails++; $display("FAIL rst_data: got %h, expected 0", bus.gpio_data); end
    tests++; if (bus.gpio_sclk !== 1'b0) begin fails++; $display("FAIL rst_sclk: got %b, expected 0", bus.gpio_sclk); end
    tests++; if (bus.gpio_done !== 1'b0) begin fails++; $display("FAIL rst_done: got %b, expected 0", bus.gpio_done); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b, expected 0", bus.busy); end
    repeat (3) @(negedge CLOCK_50);
    #1 resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLOCK_50); #1;
      if ({bus.grant, bus.nib_rd, bus.gpio_data, bus.gpio_sclk, bus.gpio_done, bus.busy} !== 10'b0) bad++;
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL idle_outputs: %0d non-zero cycles, expected 0", bad); end
  endtask

  task automatic test_single();
    int t0, bad, alt_bad;
    bit ok;
    clr_tok = clr_tok + 1;
    @(negedge CLOCK_50); #1;
    pat_mode = 0;
    bus.req  = 2'b01;
    t0 = cyc;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLOCK_50); #1;
      if (grant_rise_q.size() > 0) begin ok = 1; break; end
    end
    bus.req = 2'b00;
    tests++; if (!ok) begin fails++; $display("FAIL single_grant_timeout: no grant, expected one"); end
    tests++; if (grant_seq_q[0] !== 2'b01) begin fails++; $display("FAIL single_grant: got %b, expected 01", grant_seq_q[0]); end
    tests++; if (grant_rise_q[0] - t0 !== 1) begin fails++; $display("FAIL single_grant_delay: got %0d, expected 1", grant_rise_q[0] - t0); end
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLOCK_50); #1;
      if (grant_len_q.size() > 0) begin ok = 1; break; end
    end
    tests++; if (!ok) begin fails++; $display("FAIL single_release_timeout: grant held, expected release"); end
    tests++; if (grant_len_q[0] !== MSG_CYCLES) begin fails++; $display("FAIL single_grant_len: got %0d, expected %0d", grant_len_q[0], MSG_CYCLES); end
    tests++; if (rd_cyc_q.size() !== 32) begin fails++; $display("FAIL single_nib_rd_count: got %0d, expected 32", rd_cyc_q.size()); end
    tests++; if (rd_cyc_q[0] - grant_rise_q[0] !== 1) begin fails++; $display("FAIL single_first_rd: got %0d, expected 1", rd_cyc_q[0] - grant_rise_q[0]); end
    bad = 0;
    for (int i = 1; i < rd_cyc_q.size(); i++) if (rd_cyc_q[i] - rd_cyc_q[i-1] != 8) bad++;
    tests++; if (bad !== 0) begin fails++; $display("FAIL single_rd_spacing: %0d gaps not 8, expected 0", bad); end
    tests++; if (obs_q.size() !== 32) begin fails++; $display("FAIL single_sclk_count: got %0d, expected 32", obs_q.size()); end
    alt_bad = 0;
    for (int i = 0; i < 32; i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL single_data[%0d]: got %h, expected %h", i, obs_q[i], exp_q[i]); end
      if (obs_q[i] !== 4'(i % 2)) alt_bad++;
    end
    tests++; if (alt_bad !== 0) begin fails++; $display("FAIL single_alternating: %0d wrong nibbles, expected 0", alt_bad); end
    tests++; if (done_len_q[0] !== 4) begin fails++; $display("FAIL single_done_len: got %0d, expected 4", done_len_q[0]); end
    tests++; if (done_gap_q[0] !== 1) begin fails++; $display("FAIL single_done_gap: got %0d, expected 1", done_gap_q[0]); end
    tests++; if (overlap_err !== 0) begin fails++; $display("FAIL single_sclk_done_overlap: got %0d, expected 0", overlap_err); end
  endtask

  task automatic test_contention();
    logic [1:0] exp_g[4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    int bad, len_bad, src_bad;
    bit ok;
    do_reset(2'b00);
    pat_mode = 1;
    bus.req  = 2'b11;
    ok = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge CLOCK_50); #1;
      if (grant_len_q.size() >= 4) begin ok = 1; break; end
    end
    bus.req = 2'b00;
    tests++; if (!ok) begin fails++; $display("FAIL contention_timeout: %0d messages, expected 4", grant_len_q.size()); end
    for (int m = 0; m < 4; m++) begin
      tests++;
      if (grant_seq_q[m] !== exp_g[m]) begin fails++; $display("FAIL contention_grant[%0d]: got %b, expected %b", m, grant_seq_q[m], exp_g[m]); end
    end
    len_bad = 0;
    for (int m = 0; m < 4; m++) if (grant_len_q[m] != MSG_CYCLES) len_bad++;
    tests++; if (len_bad !== 0) begin fails++; $display("FAIL contention_msg_len: %0d wrong lengths, expected 0", len_bad); end
    tests++; if (rd_cyc_q.size() !== 128) begin fails++; $display("FAIL contention_nib_rd_count: got %0d, expected 128", rd_cyc_q.size()); end
    bad = 0; src_bad = 0;
    for (int i = 0; i < 128; i++) begin
      if (obs_q[i] !== exp_q[i]) bad++;
      if (obs_q[i][3] !== 1'(((i / 32) % 2))) src_bad++;
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL contention_data: %0d mismatched nibbles, expected 0", bad); end
    tests++; if (src_bad !== 0) begin fails++; $display("FAIL contention_source: %0d nibbles from wrong requester, expected 0", src_bad); end
    tests++; if (onehot_err !== 0) begin fails++; $display("FAIL contention_onehot: got %0d, expected 0", onehot_err); end
    tests++; if (overlap_err !== 0) begin fails++; $display("FAIL contention_sclk_done_overlap: got %0d, expected 0", overlap_err); end
  endtask

  task automatic test_drop();
    int bad;
    bit ok;
    do_reset(2'b00);
    pat_mode = 0;
    bus.req  = 2'b01;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLOCK_50); #1;
      if (rd_cyc_q.size() >= 5) begin ok = 1; break; end
    end
    bus.req = 2'b00;
    tests++; if (!ok) begin fails++; $display("FAIL drop_start_timeout: got %0d reads, expected 5", rd_cyc_q.size()); end
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLOCK_50); #1;
      if (grant_len_q.size() > 0) begin ok = 1; break; end
    end
    tests++; if (!ok) begin fails++; $display("FAIL drop_release_timeout: grant held, expected release"); end
    tests++; if (rd_cyc_q.size() !== 32) begin fails++; $display("FAIL drop_nib_rd_count: got %0d, expected 32", rd_cyc_q.size()); end
    tests++; if (done_len_q[0] !== 4) begin fails++; $display("FAIL drop_done_len: got %0d, expected 4", done_len_q[0]); end
    tests++; if (grant_len_q[0] !== MSG_CYCLES) begin fails++; $display("FAIL drop_grant_len: got %0d, expected %0d", grant_len_q[0], MSG_CYCLES); end
    bad = 0;
    for (int i = 0; i < 32; i++) if (obs_q[i] !== exp_q[i]) bad++;
    tests++; if (bad !== 0) begin fails++; $display("FAIL drop_data: %0d mismatched nibbles, expected 0", bad); end
  endtask

  task automatic test_reset_mid();
    int bad;
    bit ok;
    do_reset(2'b00);
    pat_mode = 0;
    bus.req  = 2'b01;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLOCK_50); #1;
      if (obs_q.size() >= 10 && bus.gpio_sclk === 1'b1) begin ok = 1; break; end
    end
    tests++; if (!ok) begin fails++; $display("FAIL mid_reach_timeout: got %0d high phases, expected 10", obs_q.size()); end
    #1 resetn = 1'b0;
    #1;
    tests++; if (bus.grant !== 2'b00) begin fails++; $display("FAIL mid_rst_grant: got %b, expected 00", bus.grant); end
    tests++; if (bus.gpio_sclk !== 1'b0) begin fails++; $display("FAIL mid_rst_sclk: got %b, expected 0", bus.gpio_sclk); end
    tests++; if (bus.gpio_data !== 4'h0) begin fails++; $display("FAIL mid_rst_data: got %h, expected 0", bus.gpio_data); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL mid_rst_busy: got %b, expected 0", bus.busy); end
    tests++; if ({bus.nib_rd, bus.gpio_done} !== 2'b00) begin fails++; $display("FAIL mid_rst_strobes: got %b, expected 00", {bus.nib_rd, bus.gpio_done}); end
    bus.req = 2'b10;
    repeat (2) @(negedge CLOCK_50);
    clr_tok = clr_tok + 1;
    @(negedge CLOCK_50); #1;
    resetn = 1'b1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLOCK_50); #1;
      if (grant_rise_q.size() > 0) begin ok = 1; break; end
    end
    bus.req = 2'b00;
    tests++; if (grant_seq_q[0] !== 2'b10) begin fails++; $display("FAIL mid_new_grant: got %b, expected 10", grant_seq_q[0]); end
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLOCK_50); #1;
      if (grant_len_q.size() > 0) begin ok = 1; break; end
    end
    tests++; if (!ok) begin fails++; $display("FAIL mid_release_timeout: grant held, expected release"); end
    tests++; if (rd_cyc_q.size() !== 32) begin fails++; $display("FAIL mid_nib_rd_count: got %0d, expected 32", rd_cyc_q.size()); end
    tests++; if (grant_len_q[0] !== MSG_CYCLES) begin fails++; $display("FAIL mid_grant_len: got %0d, expected %0d", grant_len_q[0], MSG_CYCLES); end
    bad = 0;
    for (int i = 0; i < 32; i++) if (obs_q[i] !== exp_q[i] || obs_q[i] !== 4'(i % 2)) bad++;
    tests++; if (bad !== 0) begin fails++; $display("FAIL mid_fresh_data: %0d mismatched nibbles, expected 0", bad); end
  endtask

`ifdef GPIO_LINK_PARITY_EN
  task automatic test_parity();
    int bad;
    bit ok;
    do_reset(2'b00);
    pat_mode = 2;
    bus.req  = 2'b01;
    ok = 0;
    for (int i = 0; i < 420; i++) begin
      @(negedge CLOCK_50); #1;
      if (grant_rise_q.size() > 0) bus.req = 2'b00;
      if (grant_len_q.size() > 0) begin ok = 1; break; end
    end
    tests++; if (!ok) begin fails++; $display("FAIL parity_timeout: grant held, expected release"); end
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (obs_q[i] !== ((i % 2 == 0) ? 4'b1011 : 4'b0110)) bad++;
      if (obs_par_q[i] !== ((i % 2 == 0) ? 1'b1 : 1'b0)) bad++;
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL parity_values: %0d wrong samples, expected 0", bad); end
  endtask
`endif

  initial begin
    bus.req       = 2'b00;
    bus.tx_nibble = 4'h0;
    #2;
    test_reset();
    test_single();
    test_contention();
    test_drop();
    test_reset_mid();
`ifdef GPIO_LINK_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
